// File: rtl/ex_regincr_pkg.sv
// Shared defaults and response record for the register-plus-increment arbiter.
// The record typedef is sized for the default configuration.
package ex_regincr_pkg;

   localparam int NREQS_DEFAULT = 4;
   localparam int NBITS_DEFAULT = 8;
   localparam int ID_W_DEFAULT  = $clog2(NREQS_DEFAULT);

   typedef struct packed {
      logic [ID_W_DEFAULT-1:0]  id;
      logic [NBITS_DEFAULT-1:0] data;
   } resp_rec_t;

endpackage

// File: rtl/ex_regincr_RoundRobinArb.sv
// Combinational round-robin arbiter: picks the first request at or above i_ptr,
// wrapping around. The pointer register lives in the parent.
module ex_regincr_RoundRobinArb #(
   parameter  int N  = 4,
   localparam int IW = $clog2(N)
) (
   input  logic [N-1:0]  i_req,
   input  logic [IW-1:0] i_ptr,
   input  logic          i_en,
   output logic [N-1:0]  o_grant,
   output logic [IW-1:0] o_idx,
   output logic          o_any
);

   // Scan from the farthest candidate down to i_ptr so the closest hit wins.
   always_comb begin
      int j;
      o_grant = '0;
      o_idx   = '0;
      o_any   = 1'b0;
      j       = 0;
      if (i_en) begin
         for (int k = N - 1; k >= 0; k--) begin
            j = int'(i_ptr) + k;
            if (j >= N) j = j - N;
            if (i_req[j]) begin
               o_grant = N'(1) << j;
               o_idx   = IW'(j);
               o_any   = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/ex_regincr_incr_arbiter.sv
// Shares one register + incrementer among nreqs val/rdy requesters with
// round-robin arbitration; the +1 sits after the response register.
module ex_regincr_incr_arbiter
   import ex_regincr_pkg::*;
#(
   parameter  int nreqs = NREQS_DEFAULT,
   parameter  int nbits = NBITS_DEFAULT,
   localparam int IW    = $clog2(nreqs)
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [nreqs-1:0]       req_val,
   output logic [nreqs-1:0]       req_rdy,
   input  logic [nreqs*nbits-1:0] req_msg,
   output logic                   resp_val,
   input  logic                   resp_rdy,
   output logic [nbits-1:0]       resp_msg,
   output logic [IW-1:0]          resp_id,
   output logic [IW-1:0]          dbg_ptr
);

   // Handshake: a transfer happens on a port in any cycle where its val and rdy
   // are both high; rdy never depends on the message payload.

   logic             r_resp_val;
   logic [IW-1:0]    r_resp_id;
   logic [nbits-1:0] r_resp_data;
   logic [IW-1:0]    r_ptr;

   logic             w_go;
   logic             w_arb_en;
   logic [nreqs-1:0] w_grant;
   logic [IW-1:0]    w_grant_idx;
   logic             w_xfer;
   logic [IW-1:0]    w_ptr_next;
   logic [nbits-1:0] w_sel_msg;

   assign w_go     = !r_resp_val || resp_rdy;
   assign w_arb_en = w_go && !reset;

   ex_regincr_RoundRobinArb #(
      .N (nreqs)
   ) u_arb (
      .i_req   (req_val),
      .i_ptr   (r_ptr),
      .i_en    (w_arb_en),
      .o_grant (w_grant),
      .o_idx   (w_grant_idx),
      .o_any   (w_xfer)
   );

   assign req_rdy    = w_grant;
   assign w_ptr_next = (w_grant_idx == IW'(nreqs - 1)) ? '0 : w_grant_idx + IW'(1);

   always_comb begin
      w_sel_msg = req_msg[int'(w_grant_idx)*nbits +: nbits];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_resp_val  <= 1'b0;
         r_resp_id   <= '0;
         r_resp_data <= '0;
         r_ptr       <= '0;
      end else if (w_xfer) begin
         r_resp_val  <= 1'b1;
         r_resp_id   <= w_grant_idx;
         r_resp_data <= w_sel_msg;
         r_ptr       <= w_ptr_next;
      end else if (w_go) begin
         // Drained (or already empty) with nothing new accepted.
         r_resp_val  <= 1'b0;
      end
   end

   assign resp_val = r_resp_val;
   assign resp_id  = r_resp_id;
   assign resp_msg = r_resp_data + nbits'(1);
   assign dbg_ptr  = r_ptr;

endmodule

// File: tb/tb_ex_regincr_incr_arbiter.sv
// Directed bench for the shared register-plus-increment round-robin arbiter.
module tb_ex_regincr_incr_arbiter;
   import ex_regincr_pkg::*;

   localparam int N  = 4;
   localparam int W  = 8;
   localparam int IW = 2;

   logic           clk;
   logic           reset;
   logic [N-1:0]   req_val;
   logic [N-1:0]   req_rdy;
   logic [N*W-1:0] req_msg;
   logic           resp_val;
   logic           resp_rdy;
   logic [W-1:0]   resp_msg;
   logic [IW-1:0]  resp_id;
   logic [IW-1:0]  dbg_ptr;

   int n_checks;
   int n_errors;

   ex_regincr_incr_arbiter #(.nreqs(N), .nbits(W)) dut (
      .clk      (clk),
      .reset    (reset),
      .req_val  (req_val),
      .req_rdy  (req_rdy),
      .req_msg  (req_msg),
      .resp_val (resp_val),
      .resp_rdy (resp_rdy),
      .resp_msg (resp_msg),
      .resp_id  (resp_id),
      .dbg_ptr  (dbg_ptr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic drain();
      req_val  = '0;
      resp_rdy = 1'b1;
      tick();
   endtask

   task automatic test_reset();
      reset    = 1'b1;
      req_val  = 4'b1111;
      resp_rdy = 1'b1;
      settle();
      n_checks++;
      if (req_rdy !== 4'b0000) begin
         n_errors++; $display("FAIL reset_rdy: got %b want %b", req_rdy, 4'b0000);
      end
      tick();
      n_checks++;
      if (resp_val !== 1'b0) begin
         n_errors++; $display("FAIL reset_val: got %b want 0", resp_val);
      end
      n_checks++;
      if (resp_id !== 2'd0) begin
         n_errors++; $display("FAIL reset_id: got %0d want 0", resp_id);
      end
      n_checks++;
      if (dbg_ptr !== 2'd0) begin
         n_errors++; $display("FAIL reset_ptr: got %0d want 0", dbg_ptr);
      end
      reset   = 1'b0;
      req_val = '0;
      tick();
   endtask

   task automatic test_single();
      req_val        = 4'b0001;
      req_msg[7:0]   = 8'h13;
      resp_rdy       = 1'b1;
      settle();
      n_checks++;
      if (req_rdy !== 4'b0001) begin
         n_errors++; $display("FAIL single_rdy: got %b want %b", req_rdy, 4'b0001);
      end
      tick();
      req_val = '0;
      n_checks++;
      if (resp_val !== 1'b1 || resp_msg !== 8'h14 || resp_id !== 2'd0) begin
         n_errors++;
         $display("FAIL single_resp: got val=%b msg=%h id=%0d want val=1 msg=14 id=0", resp_val, resp_msg, resp_id);
      end
      n_checks++;
      if (dbg_ptr !== 2'd1) begin
         n_errors++; $display("FAIL single_ptr: got %0d want 1", dbg_ptr);
      end
      drain();
      n_checks++;
      if (resp_val !== 1'b0) begin
         n_errors++; $display("FAIL single_drain: got %b want 0", resp_val);
      end
   endtask

   task automatic test_wrap();
      req_val        = 4'b0100;
      req_msg[23:16] = 8'hFF;
      resp_rdy       = 1'b1;
      settle();
      n_checks++;
      if (req_rdy !== 4'b0100) begin
         n_errors++; $display("FAIL wrap_rdy: got %b want %b", req_rdy, 4'b0100);
      end
      tick();
      req_val = '0;
      n_checks++;
      if (resp_val !== 1'b1 || resp_msg !== 8'h00 || resp_id !== 2'd2) begin
         n_errors++;
         $display("FAIL wrap_resp: got val=%b msg=%h id=%0d want val=1 msg=00 id=2", resp_val, resp_msg, resp_id);
      end
      drain();
   endtask

   task automatic test_round_robin();
      resp_rec_t    exp_rec [5];
      logic [N-1:0] exp_rdy [5];
      exp_rec[0] = '{id: 2'd0, data: 8'h11}; exp_rdy[0] = 4'b0001;
      exp_rec[1] = '{id: 2'd1, data: 8'h21}; exp_rdy[1] = 4'b0010;
      exp_rec[2] = '{id: 2'd2, data: 8'h31}; exp_rdy[2] = 4'b0100;
      exp_rec[3] = '{id: 2'd3, data: 8'h41}; exp_rdy[3] = 4'b1000;
      exp_rec[4] = '{id: 2'd0, data: 8'h11}; exp_rdy[4] = 4'b0001;
      reset = 1'b1;
      tick();
      reset    = 1'b0;
      req_msg  = {8'h40, 8'h30, 8'h20, 8'h10};
      req_val  = 4'b1111;
      resp_rdy = 1'b1;
      for (int i = 0; i < 5; i++) begin
         settle();
         n_checks++;
         if (req_rdy !== exp_rdy[i]) begin
            n_errors++; $display("FAIL rr_rdy[%0d]: got %b want %b", i, req_rdy, exp_rdy[i]);
         end
         tick();
         n_checks++;
         if (resp_val !== 1'b1 || resp_id !== exp_rec[i].id || resp_msg !== exp_rec[i].data) begin
            n_errors++;
            $display("FAIL rr_resp[%0d]: got val=%b id=%0d msg=%h want val=1 id=%0d msg=%h",
                     i, resp_val, resp_id, resp_msg, exp_rec[i].id, exp_rec[i].data);
         end
      end
      n_checks++;
      if (dbg_ptr !== 2'd1) begin
         n_errors++; $display("FAIL rr_ptr: got %0d want 1", dbg_ptr);
      end
      drain();
   endtask

   task automatic test_backpressure();
      req_msg      = {8'h00, 8'h00, 8'h27, 8'h55};
      req_val      = 4'b0010;
      resp_rdy     = 1'b1;
      tick();
      n_checks++;
      if (resp_val !== 1'b1 || resp_msg !== 8'h28 || resp_id !== 2'd1) begin
         n_errors++;
         $display("FAIL bp_first: got val=%b msg=%h id=%0d want val=1 msg=28 id=1", resp_val, resp_msg, resp_id);
      end
      req_val  = 4'b0011;
      resp_rdy = 1'b0;
      for (int i = 0; i < 3; i++) begin
         settle();
         n_checks++;
         if (req_rdy !== 4'b0000) begin
            n_errors++; $display("FAIL bp_stall_rdy[%0d]: got %b want 0000", i, req_rdy);
         end
         tick();
         n_checks++;
         if (resp_val !== 1'b1 || resp_msg !== 8'h28 || resp_id !== 2'd1) begin
            n_errors++;
            $display("FAIL bp_stall_hold[%0d]: got val=%b msg=%h id=%0d want val=1 msg=28 id=1",
                     i, resp_val, resp_msg, resp_id);
         end
      end
      resp_rdy = 1'b1;
      settle();
      n_checks++;
      if (req_rdy !== 4'b0001) begin
         n_errors++; $display("FAIL bp_release_rdy: got %b want 0001", req_rdy);
      end
      tick();
      req_val = '0;
      n_checks++;
      if (resp_val !== 1'b1 || resp_msg !== 8'h56 || resp_id !== 2'd0) begin
         n_errors++;
         $display("FAIL bp_release_resp: got val=%b msg=%h id=%0d want val=1 msg=56 id=0", resp_val, resp_msg, resp_id);
      end
      drain();
   endtask

   task automatic test_reset_mid();
      req_msg  = {8'h00, 8'h07, 8'h00, 8'h9A};
      req_val  = 4'b0100;
      resp_rdy = 1'b1;
      tick();
      req_val  = '0;
      resp_rdy = 1'b0;
      n_checks++;
      if (resp_val !== 1'b1 || resp_msg !== 8'h08) begin
         n_errors++; $display("FAIL mid_pending: got val=%b msg=%h want val=1 msg=08", resp_val, resp_msg);
      end
      reset   = 1'b1;
      req_val = 4'b1111;
      settle();
      n_checks++;
      if (req_rdy !== 4'b0000) begin
         n_errors++; $display("FAIL mid_rdy_in_reset: got %b want 0000", req_rdy);
      end
      tick();
      reset = 1'b0;
      n_checks++;
      if (resp_val !== 1'b0 || dbg_ptr !== 2'd0) begin
         n_errors++; $display("FAIL mid_after_reset: got val=%b ptr=%0d want val=0 ptr=0", resp_val, dbg_ptr);
      end
      resp_rdy = 1'b1;
      settle();
      n_checks++;
      if (req_rdy !== 4'b0001) begin
         n_errors++; $display("FAIL mid_first_grant: got %b want 0001", req_rdy);
      end
      tick();
      req_val = '0;
      n_checks++;
      if (resp_val !== 1'b1 || resp_id !== 2'd0 || resp_msg !== 8'h9B) begin
         n_errors++;
         $display("FAIL mid_first_resp: got val=%b id=%0d msg=%h want val=1 id=0 msg=9b", resp_val, resp_id, resp_msg);
      end
      drain();
   endtask

   task automatic test_no_requests();
      req_val  = '0;
      resp_rdy = 1'b1;
      for (int i = 0; i < 5; i++) begin
         settle();
         n_checks++;
         if (req_rdy !== 4'b0000) begin
            n_errors++; $display("FAIL idle_rdy[%0d]: got %b want 0000", i, req_rdy);
         end
         tick();
         n_checks++;
         if (resp_val !== 1'b0 || dbg_ptr !== 2'd1) begin
            n_errors++; $display("FAIL idle_state[%0d]: got val=%b ptr=%0d want val=0 ptr=1", i, resp_val, dbg_ptr);
         end
      end
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      reset    = 1'b1;
      req_val  = '0;
      req_msg  = '0;
      resp_rdy = 1'b0;
      tick();
      test_reset();
      test_single();
      test_wrap();
      test_round_robin();
      test_backpressure();
      test_reset_mid();
      test_no_requests();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/ex_regincr_incr_arbiter.md
# ex_regincr_incr_arbiter

Round-robin arbiter and sequencer that shares one register-plus-increment datapath (8-bit register followed by a +1 incrementer) among `nreqs` requesters. Each requester sends 8-bit values over a val/rdy request port. The block grants one requester per cycle, registers the granted value, and returns value+1 on a single shared val/rdy response port tagged with the requester index. It sits between several client blocks and the shared incrementer, replacing direct per-client instances of the register/incrementer.

## Interface
- `nreqs`, default 4: number of requesters; legal range 2..8.
- `nbits`, default 8: data width; the response is `(msg + 1) mod 2^nbits`.
- `clk` input 1: single clock; all state updates on its rising edge.
- `reset` input 1: synchronous, active-high.
- `req_val` input `nreqs`: per-requester request valid.
- `req_rdy` output `nreqs`: per-requester ready; one-hot or all-zero.
- `req_msg` input `nreqs*nbits`: flattened request data; requester i occupies bits `[i*nbits +: nbits]`.
- `resp_val` output 1: response valid.
- `resp_rdy` input 1: consumer ready.
- `resp_msg` output `nbits`: incremented value.
- `resp_id` output `$clog2(nreqs)`: index of the requester that produced the response.

## Operation
- **Pipeline.** The block has one stage: a response register holding `{val, id, data}`.
- **Accept condition.** `go = !resp_val || resp_rdy`.
- **Grant.** When `go=1`, grant the first asserted `req_val[i]`, searching upward from priority pointer `ptr` with wrap-around. Assert only `req_rdy[grant]`.
- **No grant.** When `go=0` or no `req_val` is set, `req_rdy` is all zero.
- **Combinational inputs.** `req_rdy` depends combinationally on `req_val`, `resp_val`, `resp_rdy` and `ptr`. It must never depend on `req_msg`.
- **Transfer.** A transfer occurs when `req_val[i] && req_rdy[i]`. On transfer, next-cycle `resp_val=1`, `resp_id=i` and `resp_msg = req_msg[i]+1`.
- **Increment placement.** The increment is computed on the registered value after the register, so the adder sits at the output. Wrap: 8'hFF yields 8'h00 with no carry out.
- **Drain.** If `resp_val && resp_rdy` and there is no new transfer, `resp_val` goes to 0.
- **Stall.** If `resp_val && !resp_rdy`, the response register holds `resp_msg` and `resp_id` stable and all `req_rdy` are 0.
- **Priority update.** `ptr` becomes `(grant+1) mod nreqs` only on a transfer; it is unchanged otherwise.
- **Simultaneous drain and accept.** Supported: full throughput of one transfer per cycle.

## Timing
- **Reset values.** `resp_val=0`, `ptr=0`, `req_rdy` all 0 during the reset cycle. `resp_msg` and `resp_id` are don't-care while `resp_val=0` but are reset to 0.
- **Latency.** Request accepted in cycle T leads to response visible in cycle T+1.
- **Throughput.** One transfer per cycle while `resp_rdy=1`.
- **Reset mid-operation.** Reset asserted with a pending response discards the response: `resp_val=0` the following cycle and `ptr=0`. `req_rdy` is 0 throughout reset.
- **Fairness.** With all requesters continuously valid and `resp_rdy=1`, grants go 0,1,2,3,0,... Any continuously valid requester is served within `nreqs` transfers.

## Structure
- **Shared package.** `ex_regincr_pkg` holds the `nreqs`/`nbits` defaults and a typedef for the response record `{id, data}`.
- **Sub-module.** `ex_regincr_RoundRobinArb`: parameterized combinational round-robin arbiter.
  - Inputs: request vector, `ptr`, enable.
  - Output: one-hot grant plus encoded index.
  - `ptr` state lives in the top block.
- **Top block.** Contains the response register, the incrementer, the `ptr` register and the val/rdy glue.

## Test plan
- **Single requester.** After reset, `req_val=4'b0001`, msg0=8'h13, `resp_rdy=1` -> `req_rdy=4'b0001` in the same cycle. Next cycle `resp_val=1`, `resp_msg=8'h14`, `resp_id=0`.
- **Wrap.** Requester 2 sends 8'hFF -> `resp_msg=8'h00`, `resp_id=2`.
- **Round-robin.** All four valid with msgs 8'h10/8'h20/8'h30/8'h40, `resp_rdy=1` for 5 cycles -> `resp_id` sequence 0,1,2,3,0 and `resp_msg` 8'h11,8'h21,8'h31,8'h41,8'h11.
- **Backpressure.** Requester 1 sends 8'h27, then `resp_rdy=0` for 3 cycles with requesters 0 and 1 valid.
  - During the stall: `resp_msg` stays 8'h28, `resp_id=1`, `req_rdy=0`.
  - On `resp_rdy=1`: requester 2 is not valid, so the next grant is requester 0 (searching from `ptr`=2 with wrap).
- **Reset mid-operation.** Pending response with `resp_rdy=0`, assert `reset` for 1 cycle -> `resp_val=0` after reset. Then with all requesters valid, the first grant is requester 0.
- **No requests.** `req_val=0` for 5 cycles after a response drains -> `resp_val=0`, `req_rdy=0`, `ptr` unchanged.
